spatz_vrf_wport_arbiter: RTL and testbench

- Arbitrates vector-register write requests from several producers (VFU, VLSU, VSLDU, ...) onto the single write port of each VRF bank.
- Fixed priority by requester index, with a per-requester starvation counter that escalates a long-denied requester above the others.
- Valid/ready handshake per requester; registered one-cycle output to the bank write ports.
- Sits between the functional units and the VRF bank array.

---
 rtl/spatz_vrf_wport_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_spatz_vrf_wport_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_vrf_wport_arbiter.sv
// VRF write-port arbiter: maps NrReq write producers onto NrBanks single-ported banks.
// Fixed priority by requester index; requesters denied StarveLimit cycles in a row escalate.
// Bank write ports are registered (one cycle after the handshake).
// Optional performance counters are enabled by defining SPATZ_VRF_ARB_PERF_EN.
module spatz_vrf_wport_arbiter #(
    parameter int unsigned NrReq       = 3,
    parameter int unsigned NrBanks     = 4,
    parameter int unsigned AddrWidth   = 5,
    parameter int unsigned DataWidth   = 256,
    parameter int unsigned StarveLimit = 8,
    localparam int unsigned BankW      = (NrBanks > 1) ? $clog2(NrBanks) : 1,
    localparam int unsigned OwnW       = (NrReq > 1) ? $clog2(NrReq) : 1,
    localparam int unsigned BeW        = DataWidth / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrReq-1:0]               req_valid_i,
    output logic [NrReq-1:0]               req_ready_o,
    input  logic [NrReq*BankW-1:0]         req_bank_i,
    input  logic [NrReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NrReq*DataWidth-1:0]     req_data_i,
    input  logic [NrReq*BeW-1:0]           req_be_i,
    input  logic [NrBanks-1:0]             bank_stall_i,
    output logic [NrBanks-1:0]             bank_we_o,
    output logic [NrBanks*AddrWidth-1:0]   bank_addr_o,
    output logic [NrBanks*DataWidth-1:0]   bank_data_o,
    output logic [NrBanks*BeW-1:0]         bank_be_o,
    output logic [NrBanks*OwnW-1:0]        bank_owner_o
`ifdef SPATZ_VRF_ARB_PERF_EN
    ,
    input  logic                           perf_clr_i,
    output logic [NrReq*16-1:0]            perf_conflict_o,
    output logic [NrReq*16-1:0]            perf_escalate_o
`endif
);

    localparam logic [7:0] Limit = 8'(StarveLimit);

    if (NrReq < 1) begin : g_err_nrreq
        $error("NrReq must be at least 1");
    end
    if ((NrBanks < 2) || ((NrBanks & (NrBanks - 1)) != 0)) begin : g_err_nrbanks
        $error("NrBanks must be a power of two >= 2");
    end
    if ((StarveLimit < 1) || (StarveLimit > 255)) begin : g_err_limit
        $error("StarveLimit must be within 1..255");
    end
    if ((DataWidth % 8) != 0) begin : g_err_dw
        $error("DataWidth must be a multiple of 8");
    end

    logic [NrReq-1:0][7:0]             r_starve;
    logic [NrBanks-1:0]                r_we;
    logic [NrBanks*AddrWidth-1:0]      r_addr;
    logic [NrBanks*DataWidth-1:0]      r_data;
    logic [NrBanks*BeW-1:0]            r_be;
    logic [NrBanks*OwnW-1:0]           r_owner;

    logic [NrReq-1:0]                  w_starving;
    logic [NrReq-1:0]                  w_ready;
    logic [NrBanks-1:0][NrReq-1:0]     w_cand;
    logic [NrBanks-1:0]                w_any;
    logic [NrBanks-1:0]                w_stv;
    logic [NrBanks-1:0][OwnW-1:0]      w_any_idx;
    logic [NrBanks-1:0][OwnW-1:0]      w_stv_idx;
    logic [NrBanks-1:0][OwnW-1:0]      w_bank_idx;
    logic [NrBanks-1:0]                w_bank_gnt;

    // Candidate matrix: valid requester aimed at a bank that is not stalled
    always_comb begin
        w_cand     = '0;
        w_starving = '0;
        for (int i = 0; i < int'(NrReq); i++) begin
            w_starving[i] = (r_starve[i] == Limit);
            for (int b = 0; b < int'(NrBanks); b++) begin
                w_cand[b][i] = req_valid_i[i] && !bank_stall_i[b] &&
                               (req_bank_i[i*BankW +: BankW] == BankW'(b));
            end
        end
    end

    // Per-bank pick: lowest starving candidate, else lowest candidate
    always_comb begin
        w_any      = '0;
        w_stv      = '0;
        w_any_idx  = '0;
        w_stv_idx  = '0;
        w_bank_idx = '0;
        w_bank_gnt = '0;
        w_ready    = '0;
        for (int b = 0; b < int'(NrBanks); b++) begin
            for (int i = int'(NrReq) - 1; i >= 0; i--) begin
                if (w_cand[b][i]) begin
                    w_any[b]     = 1'b1;
                    w_any_idx[b] = OwnW'(i);
                    if (w_starving[i]) begin
                        w_stv[b]     = 1'b1;
                        w_stv_idx[b] = OwnW'(i);
                    end
                end
            end
            w_bank_gnt[b] = w_any[b];
            w_bank_idx[b] = w_stv[b] ? w_stv_idx[b] : w_any_idx[b];
            if (w_bank_gnt[b] && !rst_i) begin
                w_ready[w_bank_idx[b]] = 1'b1;
            end
        end
    end

    assign req_ready_o = w_ready;

    // Bank write registers and starvation counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we     <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_be     <= '0;
            r_owner  <= '0;
            r_starve <= '0;
        end else begin
            for (int b = 0; b < int'(NrBanks); b++) begin
                r_we[b] <= w_bank_gnt[b];
                if (w_bank_gnt[b]) begin
                    r_addr[b*AddrWidth +: AddrWidth] <=
                        req_addr_i[int'(w_bank_idx[b])*AddrWidth +: AddrWidth];
                    r_data[b*DataWidth +: DataWidth] <=
                        req_data_i[int'(w_bank_idx[b])*DataWidth +: DataWidth];
                    r_be[b*BeW +: BeW]       <= req_be_i[int'(w_bank_idx[b])*BeW +: BeW];
                    r_owner[b*OwnW +: OwnW]  <= w_bank_idx[b];
                end
            end
            for (int i = 0; i < int'(NrReq); i++) begin
                if (req_valid_i[i] && !w_ready[i]) begin
                    // Saturate so an escalated requester stays escalated until served
                    if (r_starve[i] != Limit) r_starve[i] <= r_starve[i] + 8'd1;
                end else begin
                    r_starve[i] <= '0;
                end
            end
        end
    end

    assign bank_we_o    = r_we;
    assign bank_addr_o  = r_addr;
    assign bank_data_o  = r_data;
    assign bank_be_o    = r_be;
    assign bank_owner_o = r_owner;

`ifdef SPATZ_VRF_ARB_PERF_EN
    logic [NrReq-1:0][15:0] r_perf_conf;
    logic [NrReq-1:0][15:0] r_perf_esc;

    // Saturating conflict / escalation counters with synchronous clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_conf <= '0;
            r_perf_esc  <= '0;
        end else if (perf_clr_i) begin
            r_perf_conf <= '0;
            r_perf_esc  <= '0;
        end else begin
            for (int i = 0; i < int'(NrReq); i++) begin
                if (req_valid_i[i] && !w_ready[i] && (r_perf_conf[i] != 16'hFFFF)) begin
                    r_perf_conf[i] <= r_perf_conf[i] + 16'd1;
                end
                if (w_ready[i] && w_starving[i] && (r_perf_esc[i] != 16'hFFFF)) begin
                    r_perf_esc[i] <= r_perf_esc[i] + 16'd1;
                end
            end
        end
    end

    assign perf_conflict_o = r_perf_conf;
    assign perf_escalate_o = r_perf_esc;
`else
    // Performance counters not built; arbitration is unaffected.
`endif

`ifndef SYNTHESIS
    logic [NrReq-1:0]                              r_pend;
    logic [NrReq-1:0][BankW+AddrWidth+DataWidth+BeW-1:0] r_hold;
    logic [NrReq-1:0][BankW+AddrWidth+DataWidth+BeW-1:0] w_fields;

    // Request payload snapshot for the stability check
    always_comb begin
        w_fields = '0;
        for (int i = 0; i < int'(NrReq); i++) begin
            w_fields[i] = {req_bank_i[i*BankW +: BankW], req_addr_i[i*AddrWidth +: AddrWidth],
                           req_data_i[i*DataWidth +: DataWidth], req_be_i[i*BeW +: BeW]};
        end
    end

    // Remember which requests are still pending after this cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= '0;
            r_hold <= '0;
        end else begin
            r_pend <= req_valid_i & ~w_ready;
            r_hold <= w_fields;
        end
    end

    // A pending request must keep its payload until the handshake
    always @(posedge clk_i) begin
        for (int i = 0; i < int'(NrReq); i++) begin
            if (!rst_i && r_pend[i] && req_valid_i[i]) begin
                assert (w_fields[i] == r_hold[i])
                else $error("requester %0d changed payload while pending", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_spatz_vrf_wport_arbiter.sv
// Directed bench for spatz_vrf_wport_arbiter. Two instances share stimulus:
// dut_a uses StarveLimit=4, dut_b uses StarveLimit=2.
module tb_spatz_vrf_wport_arbiter;
    localparam int unsigned NrReq   = 3;
    localparam int unsigned NrBanks = 4;
    localparam int unsigned AW      = 5;
    localparam int unsigned DW      = 32;
    localparam int unsigned BeW     = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NrReq-1:0]         valid;
    logic [NrReq*2-1:0]       bank;
    logic [NrReq*AW-1:0]      addr;
    logic [NrReq*DW-1:0]      data;
    logic [NrReq*BeW-1:0]     be;
    logic [NrBanks-1:0]       stall;

    logic [NrReq-1:0]         a_ready, b_ready;
    logic [NrBanks-1:0]       a_we, b_we;
    logic [NrBanks*AW-1:0]    a_addr, b_addr;
    logic [NrBanks*DW-1:0]    a_data, b_data;
    logic [NrBanks*BeW-1:0]   a_be, b_be;
    logic [NrBanks*2-1:0]     a_owner, b_owner;
`ifdef SPATZ_VRF_ARB_PERF_EN
    logic                     perf_clr;
    logic [NrReq*16-1:0]      a_pc, a_pe, b_pc, b_pe;
`endif

    int total = 0;
    int bad   = 0;

    spatz_vrf_wport_arbiter #(
        .NrReq(NrReq), .NrBanks(NrBanks), .AddrWidth(AW), .DataWidth(DW), .StarveLimit(4)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(a_ready),
        .req_bank_i(bank), .req_addr_i(addr), .req_data_i(data), .req_be_i(be),
        .bank_stall_i(stall), .bank_we_o(a_we), .bank_addr_o(a_addr), .bank_data_o(a_data),
        .bank_be_o(a_be), .bank_owner_o(a_owner)
`ifdef SPATZ_VRF_ARB_PERF_EN
        , .perf_clr_i(perf_clr), .perf_conflict_o(a_pc), .perf_escalate_o(a_pe)
`endif
    );

    spatz_vrf_wport_arbiter #(
        .NrReq(NrReq), .NrBanks(NrBanks), .AddrWidth(AW), .DataWidth(DW), .StarveLimit(2)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_ready_o(b_ready),
        .req_bank_i(bank), .req_addr_i(addr), .req_data_i(data), .req_be_i(be),
        .bank_stall_i(stall), .bank_we_o(b_we), .bank_addr_o(b_addr), .bank_data_o(b_data),
        .bank_be_o(b_be), .bank_owner_o(b_owner)
`ifdef SPATZ_VRF_ARB_PERF_EN
        , .perf_clr_i(perf_clr), .perf_conflict_o(b_pc), .perf_escalate_o(b_pe)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] bk,
                           input logic [4:0] ad, input logic [31:0] dt);
        valid[i]          = v;
        bank[i*2 +: 2]    = bk;
        addr[i*AW +: AW]  = ad;
        data[i*DW +: DW]  = dt;
        be[i*BeW +: BeW]  = 4'hF;
    endtask

    initial begin
        valid = '0; bank = '0; addr = '0; data = '0; be = '0; stall = '0;
`ifdef SPATZ_VRF_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_we", a_we, 0);
        check("rst_addr", a_addr, 0);
        check("rst_data", a_data, 0);
        check("rst_be", a_be, 0);
        check("rst_owner", a_owner, 0);
        set_req(0, 1'b1, 2'd1, 5'd3, 32'hAAAAAAAA);
        #1 check("rst_ready", a_ready, 0);

        // First transaction right after reset release
        @(negedge clk);
        rst = 1'b0;
        #1 check("first_ready", a_ready, 3'b001);
        @(posedge clk); #1;
        check("first_we", a_we, 4'b0010);
        check("first_addr", a_addr[9:5], 5'd3);
        check("first_owner", a_owner[3:2], 2'd0);
        check("first_data", a_data[63:32], 32'hAAAAAAAA);
        check("first_be", a_be[7:4], 4'hF);
        @(negedge clk);
        valid = '0;
        @(posedge clk); #1 check("idle_we", a_we, 0);

        // Same-bank conflict on bank 2
        @(negedge clk);
        set_req(0, 1'b1, 2'd2, 5'd10, 32'd100);
        set_req(1, 1'b1, 2'd2, 5'd11, 32'd101);
        set_req(2, 1'b1, 2'd2, 5'd12, 32'd102);
        #1 check("conf_ready0", a_ready, 3'b001);
        @(posedge clk); #1;
        check("conf_we0", a_we, 4'b0100);
        check("conf_own0", a_owner[5:4], 2'd0);
        check("conf_addr0", a_addr[14:10], 5'd10);
        check("conf_data0", a_data[95:64], 32'd100);
        @(negedge clk);
        valid[0] = 1'b0;
        #1 check("conf_ready1", a_ready, 3'b010);
        @(posedge clk); #1;
        check("conf_we1", a_we, 4'b0100);
        check("conf_own1", a_owner[5:4], 2'd1);
        check("conf_addr1", a_addr[14:10], 5'd11);
        @(negedge clk);
        valid[1] = 1'b0;
        #1 check("conf_ready2", a_ready, 3'b100);
        @(posedge clk); #1;
        check("conf_we2", a_we, 4'b0100);
        check("conf_own2", a_owner[5:4], 2'd2);
        check("conf_data2", a_data[95:64], 32'd102);
        @(negedge clk);
        valid = '0;
        @(posedge clk); #1 check("conf_idle_we", a_we, 0);

        // Parallel banks
        @(negedge clk);
        set_req(0, 1'b1, 2'd0, 5'd1, 32'd200);
        set_req(1, 1'b1, 2'd1, 5'd2, 32'd201);
        set_req(2, 1'b1, 2'd3, 5'd4, 32'd203);
        #1;
        check("par_ready_a", a_ready, 3'b111);
        check("par_ready_b", b_ready, 3'b111);
        @(posedge clk); #1;
        check("par_we", a_we, 4'b1011);
        check("par_own3", a_owner[7:6], 2'd2);
        check("par_own1", a_owner[3:2], 2'd1);
        check("par_addr3", a_addr[19:15], 5'd4);
        check("par_data0", a_data[31:0], 32'd200);
        @(negedge clk);
        valid = '0;
`ifdef SPATZ_VRF_ARB_PERF_EN
        perf_clr = 1'b1;
`endif
        @(posedge clk);

        // Starvation on bank 0, dut_a escalates after 4 denials
        @(negedge clk);
`ifdef SPATZ_VRF_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        set_req(0, 1'b1, 2'd0, 5'd7, 32'd300);
        set_req(2, 1'b1, 2'd0, 5'd9, 32'd302);
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("starve_deny%0d", k), a_ready, 3'b001);
            @(negedge clk);
        end
        #1 check("starve_grant", a_ready, 3'b100);
        @(posedge clk); #1;
        check("starve_own", a_owner[1:0], 2'd2);
        check("starve_addr", a_addr[4:0], 5'd9);
`ifdef SPATZ_VRF_ARB_PERF_EN
        check("perf_conflict2", a_pc[47:32], 16'd4);
        check("perf_escalate2", a_pe[47:32], 16'd1);
`endif
        // req2 keeps asking: its counter restarted, so req0 wins again
        @(negedge clk);
`ifdef SPATZ_VRF_ARB_PERF_EN
        perf_clr = 1'b1;
`endif
        #1 check("starve_cleared", a_ready, 3'b001);
        @(posedge clk); #1;
        check("starve_own_after", a_owner[1:0], 2'd0);
`ifdef SPATZ_VRF_ARB_PERF_EN
        check("perf_clr_conf", a_pc[47:32], 16'd0);
        check("perf_clr_esc", a_pe[47:32], 16'd0);
`endif
        @(negedge clk);
`ifdef SPATZ_VRF_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        valid = '0;
        @(posedge clk);

        // Stall bank 1 for 3 cycles with req1 waiting
        @(negedge clk);
        stall = 4'b0010;
        set_req(1, 1'b1, 2'd1, 5'd6, 32'd401);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall_ready_a%0d", k), a_ready, 3'b000);
            check($sformatf("stall_ready_b%0d", k), b_ready, 3'b000);
            @(posedge clk); #1;
            check($sformatf("stall_we%0d", k), a_we[1], 1'b0);
            @(negedge clk);
        end
        stall = 4'b0000;
        set_req(0, 1'b1, 2'd1, 5'd5, 32'd400);
        #1;
        check("release_ready_b", b_ready, 3'b010);
        check("release_ready_a", a_ready, 3'b001);
        @(posedge clk); #1;
        check("release_own_b", b_owner[3:2], 2'd1);
        check("release_addr_b", b_addr[9:5], 5'd6);
        check("release_own_a", a_owner[3:2], 2'd0);
        check("release_addr_a", a_addr[9:5], 5'd5);
        @(negedge clk);
        valid = '0;
        @(posedge clk);

        // Reset mid-operation drops the write just accepted
        @(negedge clk);
        set_req(0, 1'b1, 2'd2, 5'd13, 32'd500);
        #1 check("mid_ready", a_ready, 3'b001);
        @(posedge clk); #1;
        check("mid_we", a_we, 4'b0100);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_we", a_we, 0);
        check("mid_rst_addr", a_addr, 0);
        check("mid_rst_ready", a_ready, 0);
        @(negedge clk);
        valid = '0;
        rst   = 1'b0;
        @(posedge clk); #1 check("post_rst_we", a_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
